// File: rtl/lcd_sequencer_pkg.sv
// Shared definitions for the LCD sequencer: FSM state encoding, HD44780-style
// command bytes, the power-on init command table and the newline code.
// Ports: none (package).
package lcd_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP   = 3'd0,
    ST_INIT    = 3'd1,
    ST_IDLE    = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam int unsigned INIT_LEN = 4;

  localparam logic [7:0] CMD_FUNC_SET   = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_ROW0_ADDR  = 8'h80;
  localparam logic [7:0] CMD_ROW1_ADDR  = 8'hC0;
  localparam logic [7:0] CHAR_NEWLINE   = 8'h0A;

  // Init table, indexed 0..INIT_LEN-1.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY_MODE;
    endcase
  endfunction

  // Set-DDRAM-address command for the start of a row.
  function automatic logic [7:0] row_addr(input logic row);
    return row ? CMD_ROW1_ADDR : CMD_ROW0_ADDR;
  endfunction

endpackage

// File: rtl/lcd_sequencer_if.sv
// Host + LCD-controller handshake bundle of the sequencer.
// Host side: char_in/char_valid/char_ready write channel, clear_req pulse, busy.
// Controller side: ctl_data/ctl_is_cmd/ctl_req out, ctl_ack back (four-phase).
interface lcd_sequencer_if;

  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       clear_req;
  logic       busy;
  logic [7:0] ctl_data;
  logic       ctl_is_cmd;
  logic       ctl_req;
  logic       ctl_ack;

  // master: the sequencer itself
  modport master (
    input  char_in, char_valid, clear_req, ctl_ack,
    output char_ready, busy, ctl_data, ctl_is_cmd, ctl_req
  );

  // slave: host and LCD controller environment
  modport slave (
    output char_in, char_valid, clear_req, ctl_ack,
    input  char_ready, busy, ctl_data, ctl_is_cmd, ctl_req
  );

endinterface

// File: rtl/lcd_char_fifo.sv
// Character FIFO between the host write port and the sequencer.
// Ports: clk/rst, wr_en/wr_data push, rd_en pop, rd_data = head (show-ahead),
// full/empty flags. Push and pop in the same cycle are both honoured.
module lcd_char_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra wrap bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/lcd_sequencer.sv
// Character LCD sequencer: power-up wait, init commands, then streams buffered
// host characters with row wrap / newline addressing and latched clear requests.
// Ports: clk, rst (async, active-high), bus (lcd_sequencer_if.master):
//   host char_in/char_valid/char_ready, clear_req, busy; controller
//   ctl_data/ctl_is_cmd/ctl_req with four-phase ctl_ack.
module lcd_sequencer
  import lcd_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int COLS         = 16,
  parameter int PWRUP_CYCLES = 2000000
) (
  input  logic           clk,
  input  logic           rst,
  lcd_sequencer_if.master bus
);

  localparam int CNT_W = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWRUP_CYCLES - 1);
  localparam int COL_W = $clog2(COLS + 1);
  localparam logic [COL_W-1:0] COL_END = COL_W'(COLS);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] pwr_cnt;
  logic [1:0]       init_idx;
  logic             init_done;
  logic             row;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_inc;
  logic             clear_pend;
  logic             addr_pend;
  logic [7:0]       ctl_data_q;
  logic             ctl_is_cmd_q;

  logic       fifo_wr;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       head_nl;

  // IDLE decisions, in priority order
  logic take_clear;
  logic take_addr;
  logic take_char;

  assign col_inc = col + COL_W'(1);
  assign head_nl = (fifo_head == CHAR_NEWLINE);
  assign fifo_wr = bus.char_valid && bus.char_ready;

  lcd_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (bus.char_in),
    .rd_en   (take_char),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_PWRUP;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_PWRUP: begin
        if (pwr_cnt == CNT_LAST) state_nxt = ST_INIT;
      end
      ST_INIT: begin
        state_nxt = ST_ISSUE;
      end
      ST_IDLE: begin
        // A newline head is consumed without a transfer; stay in IDLE.
        if (take_clear || take_addr || (take_char && !head_nl)) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        // The earliest edge that can see ctl_ack here ends a full cycle of
        // ctl_req=1, so an ack already high on entry is taken only then.
        if (bus.ctl_ack) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!bus.ctl_ack) begin
          if (!init_done && (init_idx != 2'(INIT_LEN - 1))) state_nxt = ST_INIT;
          else                                              state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_PWRUP;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.ctl_req    = (state == ST_ISSUE);
    bus.char_ready = init_done && !fifo_full;
    bus.busy       = (state != ST_IDLE) || !fifo_empty || clear_pend;
    take_clear     = 1'b0;
    take_addr      = 1'b0;
    take_char      = 1'b0;
    if (state == ST_IDLE) begin
      if (clear_pend)       take_clear = 1'b1;
      else if (addr_pend)   take_addr  = 1'b1;
      else if (!fifo_empty) take_char  = 1'b1;
    end
  end

  assign bus.ctl_data   = ctl_data_q;
  assign bus.ctl_is_cmd = ctl_is_cmd_q;

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwr_cnt      <= '0;
      init_idx     <= '0;
      init_done    <= 1'b0;
      row          <= 1'b0;
      col          <= '0;
      clear_pend   <= 1'b0;
      addr_pend    <= 1'b0;
      ctl_data_q   <= 8'h00;
      ctl_is_cmd_q <= 1'b0;
    end else begin
      if (state == ST_PWRUP && pwr_cnt != CNT_LAST) pwr_cnt <= pwr_cnt + 1'b1;

      // Init context bookkeeping once each init handshake completes.
      if (state == ST_RELEASE && !bus.ctl_ack && !init_done) begin
        if (init_idx == 2'(INIT_LEN - 1)) init_done <= 1'b1;
        else                              init_idx  <= init_idx + 1'b1;
      end

      // A new request wins over consumption, so repeats simply merge.
      if (bus.clear_req)   clear_pend <= 1'b1;
      else if (take_clear) clear_pend <= 1'b0;

      // Transfer registers load only on the transition into ISSUE.
      if (state == ST_INIT) begin
        ctl_data_q   <= init_cmd(init_idx);
        ctl_is_cmd_q <= 1'b1;
      end else if (take_clear) begin
        ctl_data_q   <= CMD_CLEAR;
        ctl_is_cmd_q <= 1'b1;
      end else if (take_addr) begin
        ctl_data_q   <= row_addr(row);
        ctl_is_cmd_q <= 1'b1;
      end else if (take_char && !head_nl) begin
        ctl_data_q   <= fifo_head;
        ctl_is_cmd_q <= 1'b0;
      end

      if (take_clear) begin
        // Clear homes the cursor, so any queued row address is redundant.
        row       <= 1'b0;
        col       <= '0;
        addr_pend <= 1'b0;
      end else if (take_addr) begin
        addr_pend <= 1'b0;
      end else if (take_char) begin
        if (head_nl || col_inc == COL_END) begin
          row       <= ~row;
          col       <= '0;
          addr_pend <= 1'b1;
        end else begin
          col <= col_inc;
        end
      end
    end
  end

endmodule
